// File: rtl/memory_stage_if.sv
// Bundle of M-side inputs, MEM/WB outputs and I/O pins between the pipeline and the memory stage.
// The master side drives the M-side inputs; the slave is the memory stage itself.
interface memory_stage_if;
    logic        StallW;
    logic        FlushW;
    logic        PCSrcM;
    logic        RegWriteM;
    logic        MemToRegM;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [3:0]  WA3M;
    logic [31:0] IoIn;

    logic [31:0] ALUOutMfwd;
    logic [31:0] ReadDataW;
    logic [31:0] ALUOutW;
    logic [3:0]  WA3W;
    logic        PCSrcW;
    logic        RegWriteW;
    logic        MemToRegW;
    logic [31:0] ResultW;
    logic [31:0] IoOut;

    modport master (
        output StallW, FlushW, PCSrcM, RegWriteM, MemToRegM, MemWriteM,
        output ALUOutM, WriteDataM, WA3M, IoIn,
        input  ALUOutMfwd, ReadDataW, ALUOutW, WA3W, PCSrcW, RegWriteW,
        input  MemToRegW, ResultW, IoOut
    );

    modport slave (
        input  StallW, FlushW, PCSrcM, RegWriteM, MemToRegM, MemWriteM,
        input  ALUOutM, WriteDataM, WA3M, IoIn,
        output ALUOutMfwd, ReadDataW, ALUOutW, WA3W, PCSrcW, RegWriteW,
        output MemToRegW, ResultW, IoOut
    );
endinterface

// File: rtl/memory_stage.sv
// Memory stage: word-addressed data RAM, small I/O window (camera in, debug out, cycle counter)
// and the MEM/WB pipeline register with reset > flush > stall > load priority.
module memory_stage #(
    parameter int          DEPTH   = 256,
    parameter logic [31:0] IO_BASE = 32'hFFFF_0000
) (
    input logic           Clk,
    input logic           reset,
    memory_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   io_out_q, io_out_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   rd_data;
    logic          is_io;
    logic [1:0]    io_sel;
    logic [AW-1:0] idx;

    logic [31:0] read_data_q, read_data_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [3:0]  wa3_q, wa3_d;
    logic        pcsrc_q, pcsrc_d;
    logic        regwrite_q, regwrite_d;
    logic        memtoreg_q, memtoreg_d;

    assign is_io  = (bus.ALUOutM[31:16] == IO_BASE[31:16]);
    assign io_sel = bus.ALUOutM[3:2];
    assign idx    = bus.ALUOutM[AW+1:2];

    always_comb begin
        rd_data = 32'd0;
        if (is_io) begin
            case (io_sel)
                2'd0:    rd_data = bus.IoIn;
                2'd1:    rd_data = io_out_q;
                2'd2:    rd_data = cnt_q;
                default: rd_data = 32'd0;
            endcase
        end else begin
            rd_data = mem_q[idx];
        end
    end

    // RAM has no reset; a store presented during reset is dropped.
    always_ff @(posedge Clk) begin
        if (!reset && bus.MemWriteM && !is_io) begin
            mem_q[idx] <= bus.WriteDataM;
        end
    end

    always_comb begin
        io_out_d = io_out_q;
        cnt_d    = cnt_q + 32'd1;
        if (bus.MemWriteM && is_io && io_sel == 2'd1) begin
            io_out_d = bus.WriteDataM;
        end
    end

    always_comb begin
        read_data_d = read_data_q;
        alu_out_d   = alu_out_q;
        wa3_d       = wa3_q;
        pcsrc_d     = pcsrc_q;
        regwrite_d  = regwrite_q;
        memtoreg_d  = memtoreg_q;
        if (bus.FlushW) begin
            read_data_d = 32'd0;
            alu_out_d   = 32'd0;
            wa3_d       = 4'd0;
            pcsrc_d     = 1'b0;
            regwrite_d  = 1'b0;
            memtoreg_d  = 1'b0;
        end else if (!bus.StallW) begin
            read_data_d = rd_data;
            alu_out_d   = bus.ALUOutM;
            wa3_d       = bus.WA3M;
            pcsrc_d     = bus.PCSrcM;
            regwrite_d  = bus.RegWriteM;
            memtoreg_d  = bus.MemToRegM;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            io_out_q    <= 32'd0;
            cnt_q       <= 32'd0;
            read_data_q <= 32'd0;
            alu_out_q   <= 32'd0;
            wa3_q       <= 4'd0;
            pcsrc_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
        end else begin
            io_out_q    <= io_out_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            alu_out_q   <= alu_out_d;
            wa3_q       <= wa3_d;
            pcsrc_q     <= pcsrc_d;
            regwrite_q  <= regwrite_d;
            memtoreg_q  <= memtoreg_d;
        end
    end

    assign bus.ALUOutMfwd = bus.ALUOutM;
    assign bus.ReadDataW  = read_data_q;
    assign bus.ALUOutW    = alu_out_q;
    assign bus.WA3W       = wa3_q;
    assign bus.PCSrcW     = pcsrc_q;
    assign bus.RegWriteW  = regwrite_q;
    assign bus.MemToRegW  = memtoreg_q;
    assign bus.ResultW    = memtoreg_q ? read_data_q : alu_out_q;
    assign bus.IoOut      = io_out_q;
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios then random traffic, each cycle checked
// against a word-array model of RAM, I/O registers, cycle count and the MEM/WB contents.
module tb_memory_stage;
    logic Clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    memory_stage_if bus ();

    memory_stage #(.DEPTH(256), .IO_BASE(32'hFFFF_0000)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Reference state
    logic [31:0] m_mem [256];
    logic [31:0] m_io, m_cnt;
    logic [31:0] w_rd, w_alu;
    logic [3:0]  w_wa;
    logic        w_pc, w_rw, w_m2r;
    bit          model_valid = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] io_in);
        if (a[31:16] == 16'hFFFF) begin
            case (a[3:2])
                2'd0:    return io_in;
                2'd1:    return m_io;
                2'd2:    return m_cnt;
                default: return 32'd0;
            endcase
        end
        return m_mem[a[9:2]];
    endfunction

    task automatic put(input bit st, input bit fl, input bit pcs, input bit rw, input bit m2r,
                       input bit mw, input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] wa);
        bus.StallW     = st;
        bus.FlushW     = fl;
        bus.PCSrcM     = pcs;
        bus.RegWriteM  = rw;
        bus.MemToRegM  = m2r;
        bus.MemWriteM  = mw;
        bus.ALUOutM    = alu;
        bus.WriteDataM = wd;
        bus.WA3M       = wa;
    endtask

    // One clock: check the zero-latency paths, advance the model, check the registered outputs.
    task automatic cycle();
        logic [31:0] rd, a;
        a = bus.ALUOutM;
        #1;
        chk("ALUOutMfwd", bus.ALUOutMfwd, a);
        if (model_valid) chk("ResultW_stable", bus.ResultW, w_m2r ? w_rd : w_alu);
        rd = model_read(a, bus.IoIn);
        @(posedge Clk);
        #1;
        if (reset) begin
            m_io = 0; m_cnt = 0;
            w_rd = 0; w_alu = 0; w_wa = 0; w_pc = 0; w_rw = 0; w_m2r = 0;
            model_valid = 1;
        end else begin
            if (bus.MemWriteM) begin
                if (a[31:16] == 16'hFFFF) begin
                    if (a[3:2] == 2'd1) m_io = bus.WriteDataM;
                end else begin
                    m_mem[a[9:2]] = bus.WriteDataM;
                end
            end
            m_cnt = m_cnt + 1;
            if (bus.FlushW) begin
                w_rd = 0; w_alu = 0; w_wa = 0; w_pc = 0; w_rw = 0; w_m2r = 0;
            end else if (!bus.StallW) begin
                w_rd = rd; w_alu = a; w_wa = bus.WA3M;
                w_pc = bus.PCSrcM; w_rw = bus.RegWriteM; w_m2r = bus.MemToRegM;
            end
        end
        if (model_valid) begin
            chk("ReadDataW", bus.ReadDataW, w_rd);
            chk("ALUOutW", bus.ALUOutW, w_alu);
            chk("WA3W", {28'd0, bus.WA3W}, {28'd0, w_wa});
            chk("PCSrcW", {31'd0, bus.PCSrcW}, {31'd0, w_pc});
            chk("RegWriteW", {31'd0, bus.RegWriteW}, {31'd0, w_rw});
            chk("MemToRegW", {31'd0, bus.MemToRegW}, {31'd0, w_m2r});
            chk("ResultW", bus.ResultW, w_m2r ? w_rd : w_alu);
            chk("IoOut", bus.IoOut, m_io);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [3:0] wa);
        put(0, 0, 0, 1, 1, 0, a, 32'd0, wa);
        cycle();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        put(0, 0, 0, 0, 0, 1, a, d, 4'd0);
        cycle();
    endtask

    logic [31:0] held_rd, held_alu;
    logic [3:0]  held_wa;

    initial begin
        bus.IoIn = 32'd0;
        reset    = 1'b1;
        put(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
        cycle();
        chk("reset_ResultW", bus.ResultW, 32'd0);
        chk("reset_IoOut", bus.IoOut, 32'd0);
        reset = 1'b0;

        // Fill RAM so every later read has a defined reference; flush keeps W clean meanwhile.
        for (int i = 0; i < 256; i++) begin
            logic [31:0] d;
            d = $urandom;
            put(0, 1, 0, 0, 0, 1, i * 4, d, 4'd0);
            cycle();
        end

        // Store then load
        store(32'h10, 32'hDEADBEEF);
        load(32'h10, 4'd5);
        chk("st_ld_ResultW", bus.ResultW, 32'hDEADBEEF);
        chk("st_ld_WA3W", {28'd0, bus.WA3W}, 32'd5);
        chk("st_ld_RegWriteW", {31'd0, bus.RegWriteW}, 32'd1);

        // Aliasing and ignored low bits
        store(32'h0000_0403, 32'h1234);
        load(32'h0, 4'd1);
        chk("alias", bus.ResultW, 32'h1234);

        // Same-cycle store and load returns old data
        store(32'h20, 32'd7);
        put(0, 0, 0, 1, 1, 1, 32'h20, 32'd9, 4'd2);
        cycle();
        chk("same_cycle_old", bus.ReadDataW, 32'd7);
        load(32'h20, 4'd2);
        chk("same_cycle_new", bus.ReadDataW, 32'd9);

        // I/O window
        bus.IoIn = 32'hCAFE;
        load(32'hFFFF_0000, 4'd3);
        chk("io_in", bus.ResultW, 32'hCAFE);
        store(32'hFFFF_0004, 32'hA5);
        chk("io_out", bus.IoOut, 32'hA5);
        store(32'hFFFF_0000, 32'h5555_5555);
        chk("io_in_store_ignored", bus.IoOut, 32'hA5);
        load(32'h0, 4'd1);
        chk("io_store_no_ram", bus.ResultW, 32'h1234);
        load(32'hFFFF_0004, 4'd4);
        chk("io_out_readback", bus.ResultW, 32'hA5);

        // Stall holds, flush clears, flush beats stall
        load(32'h10, 4'd6);
        held_rd = bus.ReadDataW; held_alu = bus.ALUOutW; held_wa = bus.WA3W;
        for (int i = 0; i < 3; i++) begin
            put(1, 0, 1, 0, 0, 0, 32'h44 + i * 4, 32'd0, 4'd9);
            cycle();
            chk("stall_rd", bus.ReadDataW, held_rd);
            chk("stall_alu", bus.ALUOutW, held_alu);
            chk("stall_wa", {28'd0, bus.WA3W}, {28'd0, held_wa});
        end
        put(0, 1, 1, 1, 1, 0, 32'h10, 32'd0, 4'd7);
        cycle();
        chk("flush_RegWriteW", {31'd0, bus.RegWriteW}, 32'd0);
        chk("flush_ResultW", bus.ResultW, 32'd0);
        load(32'h10, 4'd8);
        put(1, 1, 1, 1, 1, 0, 32'h10, 32'd0, 4'd7);
        cycle();
        chk("flush_over_stall", bus.ResultW, 32'd0);

        // Reset mid-stream
        for (int i = 0; i < 10; i++) load(32'hFFFF_0008, 4'd1);
        reset = 1'b1;
        put(0, 0, 1, 1, 1, 1, 32'hFFFF_0004, 32'hFF, 4'd3);
        cycle();
        reset = 1'b0;
        chk("rst_IoOut", bus.IoOut, 32'd0);
        chk("rst_ResultW", bus.ResultW, 32'd0);
        chk("rst_WA3W", {28'd0, bus.WA3W}, 32'd0);
        load(32'hFFFF_0008, 4'd1);
        chk("cnt_first", bus.ResultW, 32'd0);
        load(32'hFFFF_0008, 4'd1);
        chk("cnt_second", bus.ResultW, 32'd1);
        chk("rst_store_dropped", bus.IoOut, 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 3) == 0)
                a = {16'hFFFF, 12'($urandom), 2'($urandom), 2'($urandom)};
            else
                a = {22'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 2'($urandom)};
            bus.IoIn = $urandom;
            reset = ($urandom_range(0, 99) == 0);
            put($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), a, $urandom, 4'($urandom));
            cycle();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
# memory_stage

Memory stage of the five-stage ARM pipeline, directly downstream of the execute stage and its EX/MEM register. Performs data-memory loads and stores, decodes a small memory-mapped I/O window for the camera input and a debug output, and registers the results into the MEM/WB pipeline register. Drives `ResultW` back to execute for forwarding. Also drives `ALUOutMfwd`, which feeds execute's M-stage forwarding input `ADataMem`.

## Interface
Parameters:
- `DEPTH`, 256: data RAM depth in 32-bit words; power of two, minimum 4.
- `IO_BASE`, 32'hFFFF_0000: base of the I/O window; only bits [31:16] are compared.

Ports:
- `Clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `StallW`  in  1  hold MEM/WB contents.
- `FlushW`  in  1  load a bubble into MEM/WB.
- `PCSrcM`  in  1  from EX/MEM; already qualified by the condition check.
- `RegWriteM`  in  1  from EX/MEM; already qualified by the condition check.
- `MemToRegM`  in  1  select load data as result.
- `MemWriteM`  in  1  store enable.
- `ALUOutM`  in  32  effective address / ALU result.
- `WriteDataM`  in  32  store data.
- `WA3M`  in  4  destination register.
- `IoIn`  in  32  camera pixel word, sampled combinationally on read.
- `ALUOutMfwd`  out  32  equals `ALUOutM`; forwarding path to execute.
- `ReadDataW`, `ALUOutW`  out  32  registered load data and ALU result.
- `WA3W`  out  4  registered destination.
- `PCSrcW`, `RegWriteW`, `MemToRegW`  out  1  registered controls.
- `ResultW`  out  32  `MemToRegW ? ReadDataW : ALUOutW`, combinational.
- `IoOut`  out  32  debug/LED output register.

## Operation
- Address decode:
  - I/O region when `ALUOutM[31:16] == IO_BASE[31:16]`; otherwise RAM.
  - `ALUOutM[1:0]` is ignored in both regions; all accesses are word accesses.
- RAM region:
  - Index is `ALUOutM[log2(DEPTH)+1:2]`; higher bits are ignored, so addresses alias.
  - Read is asynchronous.
  - Write occurs at the clock edge when `MemWriteM` is high.
  - RAM contents are not affected by reset.
- I/O region, selected by `ALUOutM[3:2]`:
  - 0: reads `IoIn`; writes are ignored.
  - 1: `IoOut` register; read/write.
  - 2: free-running 32-bit cycle counter; reads only, writes ignored.
  - 3: reads 0; writes ignored.
- Cycle counter increments every cycle, including while `StallW` is high. Wraps from 32'hFFFF_FFFF to 0.
- Read data mux selects RAM or I/O by region. The result is captured into `ReadDataW`.
- MEM/WB register update priority: `reset` > `FlushW` > `StallW` > normal load.
  - Normal: all W outputs take their M-side values.
  - Flush: all W registers are cleared to 0.
  - Stall: all W registers hold.
- `StallW` and `FlushW` do not gate stores. Upstream deasserts `MemWriteM` as required. A repeated store to the same address is harmless.

## Timing
- Reset, one edge with `reset` high:
  - All W outputs, `ResultW`, `IoOut` and the counter become 0.
  - No store happens in that cycle.
- Load latency: address presented in cycle N produces `ReadDataW` and `ResultW` in cycle N+1.
- Store: visible to a load issued in cycle N+1 or later. A load and store to the same address in the same cycle returns the old data. The same rule applies to `IoOut`.
- `ALUOutMfwd` has zero latency (pure wire).
- `ResultW` changes only after clock edges. There is no combinational path from M-side inputs to `ResultW`.
- Counter reads return the value held before the edge: a read in cycle N returns N, counted from the deassertion of reset.
- Reset asserted mid-stream discards the in-flight W instruction. A store presented in the reset cycle is dropped.

## Test plan
- Store then load:
  - Cycle 0: store `WriteDataM`=32'hDEADBEEF to 0x10.
  - Cycle 1: load 0x10 with `MemToRegM`=1, `RegWriteM`=1, `WA3M`=5.
  - Required in cycle 2: `ResultW`=32'hDEADBEEF, `WA3W`=5, `RegWriteW`=1.
- Aliasing and alignment with `DEPTH`=256:
  - Store 32'h1234 to 0x0000_0403, then load 0x0000_0000.
  - Required: 32'h1234.
- Same-cycle store and load to 0x20 (old value 7, new value 9):
  - Required: `ReadDataW`=7 next cycle; 9 on a load one cycle later.
- I/O:
  - `IoIn`=32'hCAFE, load 0xFFFF_0000 → 32'hCAFE.
  - Store 0xA5 to 0xFFFF_0004 → `IoOut`=0xA5 next cycle.
  - Store to 0xFFFF_0000 → no effect on any state.
- Stall and flush:
  - `StallW`=1 for 3 cycles: W outputs hold.
  - `FlushW`=1: `RegWriteW`=0 and `ResultW`=0 next cycle.
  - `FlushW` and `StallW` both high: flush wins.
- Reset mid-stream:
  - Run the counter for 10 cycles, then assert `reset` together with a store of 0xFF to 0xFFFF_0004.
  - Required: counter=0, `IoOut`=0, all W outputs 0.
  - Counter reads 1 one cycle after reset deasserts.
